// File: rtl/parking_pkg.sv
// Shared parking types: FSM state encoding and occupancy width.
// Reused by the counter core and the display path.
package parking_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        IN_A,
        IN_AB,
        IN_B,
        OUT_B,
        OUT_BA,
        OUT_A
    } state_t;

    // Timeout counter width: at least 20 bits, wider if TIMEOUT needs it.
    function automatic int tmo_width(input int t);
        return ($clog2(t) > 20) ? $clog2(t) : 20;
    endfunction

endpackage

// File: rtl/parking_counter_sync2.sv
// Two-flop synchronizer for one asynchronous gate sensor.
// Clears to 0 on reset so no stale beam state survives.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;

    // Double-register the raw input into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/parking_counter.sv
// Car-park occupancy counter driven by a two-beam gate.
// Direction comes from the beam order; stuck passages time out.
module parking_counter
    import parking_pkg::*;
#(
    parameter int CAPACITY = 7,
    parameter int TIMEOUT  = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sensor_a,
    input  logic             sensor_b,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             car_in,
    output logic             car_out,
    output logic             err
);

    localparam int TW = tmo_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CAP  = CNT_W'(CAPACITY);
    localparam logic [TW-1:0]    TLIM = TW'(TIMEOUT - 1);

    logic             sa;
    logic             sb;
    state_t           state;
    state_t           state_n;
    logic [TW-1:0]    tcnt;
    logic             ent;
    logic             ext;
    logic             tmo;
    logic [CNT_W-1:0] cnt_n;
    logic             in_n;
    logic             out_n;
    logic             err_n;

    sync2 u_sync_a (
        .clk (clk),
        .rst (rst),
        .d   (sensor_a),
        .q   (sa)
    );

    sync2 u_sync_b (
        .clk (clk),
        .rst (rst),
        .d   (sensor_b),
        .q   (sb)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Beam-order FSM; a stuck passage aborts back to IDLE.
    always_comb begin
        state_n = state;
        ent     = 1'b0;
        ext     = 1'b0;
        tmo     = 1'b0;
        if (state != IDLE && tcnt == TLIM) begin
            state_n = IDLE;
            tmo     = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (sa && !sb)      state_n = IN_A;
                    else if (!sa && sb) state_n = OUT_B;
                end
                IN_A: begin
                    if (sa && sb)        state_n = IN_AB;
                    else if (!sa && !sb) state_n = IDLE;
                end
                IN_AB: begin
                    if (!sa && sb)      state_n = IN_B;
                    else if (sa && !sb) state_n = IN_A;
                end
                IN_B: begin
                    if (!sa && !sb) begin
                        state_n = IDLE;
                        ent     = 1'b1;
                    end else if (sa && sb) begin
                        state_n = IN_AB;
                    end
                end
                OUT_B: begin
                    if (sa && sb)        state_n = OUT_BA;
                    else if (!sa && !sb) state_n = IDLE;
                end
                OUT_BA: begin
                    if (sa && !sb)      state_n = OUT_A;
                    else if (!sa && sb) state_n = OUT_B;
                end
                OUT_A: begin
                    if (!sa && !sb) begin
                        state_n = IDLE;
                        ext     = 1'b1;
                    end else if (sa && sb) begin
                        state_n = OUT_BA;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Occupancy update; saturates at both ends and flags rejects.
    always_comb begin
        cnt_n = count;
        in_n  = 1'b0;
        out_n = 1'b0;
        err_n = tmo;
        if (ent) begin
            if (count < CAP) begin
                cnt_n = count + 1'b1;
                in_n  = 1'b1;
            end else begin
                err_n = 1'b1;
            end
        end
        if (ext) begin
            if (count != '0) begin
                cnt_n = count - 1'b1;
                out_n = 1'b1;
            end else begin
                err_n = 1'b1;
            end
        end
    end

    // Registered count, flags and event pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
            car_in  <= 1'b0;
            car_out <= 1'b0;
            err     <= 1'b0;
        end else begin
            count   <= cnt_n;
            full    <= (cnt_n == CAP);
            empty   <= (cnt_n == '0);
            car_in  <= in_n;
            car_out <= out_n;
            err     <= err_n;
        end
    end

    // Passage timer restarts in IDLE and on every state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                tcnt <= '0;
        else if (state == IDLE || state_n != state) tcnt <= '0;
        else                                    tcnt <= tcnt + 1'b1;
    end

endmodule
